// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, TERC4 code table, word type and aligner states.
// Code words are listed as {q9..q0}; bit 0 is the first bit on the wire.
package tmds_pkg;

  typedef logic [9:0] tmds_word_t;

  localparam tmds_word_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_word_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_word_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_word_t CTRL_TOKEN_11 = 10'b1010101011;

  // Index is the decoded nibble.
  localparam tmds_word_t TERC4_TABLE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } dec_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational classification of one 10-bit TMDS word: token, video byte and (TMDS_DEC_TERC4_EN) TERC4 nibble.
// Zero latency, no flow control; the caller registers the results.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  tmds_word_t  word,
  output logic        is_token,
  output logic [1:0]  ctrl,
  output logic [7:0]  data,
  output logic        terc4_hit,
  output logic [3:0]  terc4
);

  logic [7:0] q;

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    data     = 8'h00;
    q        = word[9] ? ~word[7:0] : word[7:0];
    case (word)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default: begin
        is_token = 1'b0;
        data[0]  = q[0];
        // word[8] selects XOR vs XNOR chaining used by the encoder
        for (int i = 1; i < 8; i++) begin
          data[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
      end
    endcase
  end

`ifdef TMDS_DEC_TERC4_EN
  always_comb begin
    terc4_hit = 1'b0;
    terc4     = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (word == TERC4_TABLE[i]) begin
        terc4_hit = 1'b1;
        terc4     = 4'(i);
      end
    end
  end
`else
  assign terc4_hit = 1'b0;
  assign terc4     = 4'h0;
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-slip word alignment on control-token runs, then token/video decode (TERC4 when TMDS_DEC_TERC4_EN).
// Two-register latency from tmds_in to decoded outputs; free-running, no backpressure.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  tmds_in,
  output logic        bitslip,
  output logic [3:0]  slip_count,
  output logic        locked,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data,
  output logic        terc4_hit,
  output logic [3:0]  terc4
);

  localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
  localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int SET_W  = (SLIP_SETTLE > 1)   ? $clog2(SLIP_SETTLE)   : 1;
  localparam int LOSS_W = (LOSS_WINDOW > 1)   ? $clog2(LOSS_WINDOW)   : 1;

  tmds_word_t        word_q;
  dec_state_t        state;
  logic [RUN_W-1:0]  run_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [LOSS_W-1:0] loss_cnt;

  logic       dec_is_token;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;
  logic       dec_terc4_hit;
  logic [3:0] dec_terc4;

  logic run_full;
  logic win_end;
  logic settle_end;
  logic loss_end;
  logic slip_now;

  assign run_full   = (run_cnt == RUN_W'(LOCK_TOKENS));
  assign win_end    = (win_cnt == WIN_W'(SEARCH_WINDOW - 1));
  assign settle_end = (settle_cnt == SET_W'(SLIP_SETTLE - 1));
  assign loss_end   = (loss_cnt == LOSS_W'(LOSS_WINDOW - 1));
  // A completed run wins over an expiring window: lock, no slip.
  assign slip_now   = (state == SEARCH) && !run_full && win_end;

  tmds_word_decode u_decode (
    .word      (word_q),
    .is_token  (dec_is_token),
    .ctrl      (dec_ctrl),
    .data      (dec_data),
    .terc4_hit (dec_terc4_hit),
    .terc4     (dec_terc4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= tmds_in;
    end
  end

  // Words seen during settling straddle the old boundary, so the run restarts after the slip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (slip_now || state == SETTLE || !dec_is_token) begin
      run_cnt <= '0;
    end else if (!run_full) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      win_cnt    <= '0;
      settle_cnt <= '0;
      loss_cnt   <= '0;
      slip_count <= 4'd0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state)
        SEARCH: begin
          if (run_full) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            loss_cnt <= '0;
            win_cnt  <= '0;
          end else if (win_end) begin
            state      <= SETTLE;
            bitslip    <= 1'b1;
            win_cnt    <= '0;
            settle_cnt <= '0;
            slip_count <= (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_end) begin
            state   <= SEARCH;
            win_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        LOCKED: begin
          // Losing lock keeps the current phase; the search resumes from it.
          if (run_full) begin
            loss_cnt <= '0;
          end else if (loss_end) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            win_cnt <= '0;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de        <= 1'b0;
      ctrl      <= 2'b00;
      data      <= 8'h00;
      terc4_hit <= 1'b0;
      terc4     <= 4'h0;
    end else if (locked) begin
      de        <= !dec_is_token;
      ctrl      <= dec_ctrl;
      data      <= dec_data;
      terc4_hit <= dec_terc4_hit;
      terc4     <= dec_terc4;
    end else begin
      de        <= 1'b0;
      ctrl      <= 2'b00;
      data      <= 8'h00;
      terc4_hit <= 1'b0;
      terc4     <= 4'h0;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: reset, aligned/misaligned lock, decode vectors, loss of lock, mid-settle reset.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  localparam int LT = 8;
  localparam int SW = 64;
  localparam int SS = 4;
  localparam int LW = 4096;
`ifdef TMDS_DEC_TERC4_EN
  localparam bit T4 = 1'b1;
`else
  localparam bit T4 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tmds_in;
  logic       bitslip;
  logic [3:0] slip_count;
  logic       locked;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic       terc4_hit;
  logic [3:0] terc4;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .LOCK_TOKENS(LT), .SEARCH_WINDOW(SW), .SLIP_SETTLE(SS), .LOSS_WINDOW(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tmds_in(tmds_in), .bitslip(bitslip),
    .slip_count(slip_count), .locked(locked), .de(de), .ctrl(ctrl),
    .data(data), .terc4_hit(terc4_hit), .terc4(terc4)
  );

  typedef struct {
    logic [9:0] word;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       hit;
    logic [3:0] nib;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  vec_t tbl[14];
  vec_t exp_q[$];

  always @(negedge clk) if (bitslip === 1'b1) pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[(i + k) % 10];
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {bitslip, slip_count, locked, de, ctrl, data, terc4_hit, terc4}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    int n_slip;
    int slip_at[4];
    int lock_cyc;
    int k_slip;
    vec_t v;

    tbl[0]  = '{CTRL_TOKEN_00, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0};
    tbl[1]  = '{CTRL_TOKEN_01, 1'b0, 2'b01, 8'h00, 1'b0, 4'h0};
    tbl[2]  = '{CTRL_TOKEN_10, 1'b0, 2'b10, 8'h00, 1'b0, 4'h0};
    tbl[3]  = '{CTRL_TOKEN_11, 1'b0, 2'b11, 8'h00, 1'b0, 4'h0};
    tbl[4]  = '{10'h100,       1'b1, 2'b00, 8'h00, 1'b0, 4'h0};
    tbl[5]  = '{10'h2FF,       1'b1, 2'b00, 8'hFE, 1'b0, 4'h0};
    tbl[6]  = '{10'h000,       1'b1, 2'b00, 8'hFE, 1'b0, 4'h0};
    tbl[7]  = '{10'h1FF,       1'b1, 2'b00, 8'h01, 1'b0, 4'h0};
    tbl[8]  = '{10'h3FF,       1'b1, 2'b00, 8'h00, 1'b0, 4'h0};
    tbl[9]  = '{10'h155,       1'b1, 2'b00, 8'hFF, 1'b0, 4'h0};
    tbl[10] = '{10'h29C,       1'b1, 2'b00, 8'h5B, T4,   4'h0};
    tbl[11] = '{10'h11E,       1'b1, 2'b00, 8'h22, T4,   T4 ? 4'h5 : 4'h0};
    tbl[12] = '{10'h2C3,       1'b1, 2'b00, 8'hBA, T4,   T4 ? 4'hF : 4'h0};
    tbl[13] = '{CTRL_TOKEN_00, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0};

    // Reset state with aligned tokens already on the input
    rst_n   = 1'b0;
    tmds_in = CTRL_TOKEN_00;
    repeat (3) step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Aligned lock: locked rises on edge LT+2 after release
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == LT + 1) chk("locked_before_edge10", locked, 1'b0);
      if (e == LT + 2) chk("locked_at_edge10", locked, 1'b1);
    end
    chk("aligned_ctrl_de", {de, ctrl, data}, 0);
    chk("aligned_slip_count", slip_count, 0);

    // Decode vectors through the two-stage pipeline
    for (int i = 0; i < 16; i++) begin
      if (i >= 2) begin
        v = exp_q.pop_front();
        chk($sformatf("vec%0d_de", i - 2), de, v.de);
        chk($sformatf("vec%0d_ctrl", i - 2), ctrl, v.ctrl);
        chk($sformatf("vec%0d_data", i - 2), data, v.data);
        chk($sformatf("vec%0d_terc4", i - 2), {terc4_hit, terc4}, {v.hit, v.nib});
      end
      if (i < 14) begin
        tmds_in = tbl[i].word;
        exp_q.push_back(tbl[i]);
      end else begin
        tmds_in = CTRL_TOKEN_00;
      end
      step();
    end
    chk("locked_after_vectors", locked, 1'b1);

    // Loss of lock: last full run seen two edges after the change, then LW cycles
    repeat (12) step();
    tmds_in = 10'h100;
    for (int k = 1; k <= LW + 2; k++) begin
      step();
      if (k == LW + 1) chk("locked_before_loss", locked, 1'b1);
      if (k == LW + 2) chk("locked_after_loss", locked, 1'b0);
    end
    chk("loss_slip_count", slip_count, 0);
    chk("no_slip_while_locked", pulses, 0);

    // Back in SEARCH: first slip one window later, then reset during SETTLE
    k_slip = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bitslip) begin
        k_slip = k;
        break;
      end
    end
    chk("slip_after_loss_delay", k_slip, SW);
    chk("slip_count_after_slip", slip_count, 1);
    step();
    chk("bitslip_one_cycle", bitslip, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midsettle_reset");

    // Misaligned lock: input 3 slips away from alignment
    off     = 7;
    tmds_in = rot(CTRL_TOKEN_00, off);
    step();
    rst_n = 1'b1;
    step();
    chk("release_slip_count", slip_count, 0);
    n_slip   = 0;
    lock_cyc = -1;
    for (int i = 0; i < 4; i++) slip_at[i] = -1;
    for (int cyc = 2; cyc <= 600; cyc++) begin
      step();
      if (bitslip) begin
        if (n_slip < 4) slip_at[n_slip] = cyc;
        n_slip++;
        off = (off + 1) % 10;
      end
      tmds_in = rot(CTRL_TOKEN_00, off);
      if (locked) begin
        lock_cyc = cyc;
        break;
      end
    end
    chk("mis_locked", locked, 1'b1);
    chk("mis_slip_pulses", n_slip, 3);
    chk("mis_first_slip", slip_at[0], SW);
    chk("mis_slip_gap1", slip_at[1] - slip_at[0], SW + SS);
    chk("mis_slip_gap2", slip_at[2] - slip_at[1], SW + SS);
    chk("mis_slip_count", slip_count, 3);
    chk("mis_lock_edge", lock_cyc, 3 * (SW + SS) - SS + SS + LT + 1);
    step();
    step();
    chk("mis_decode_token", {de, ctrl}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
